// File: rtl/irq_sequencer_if.sv
// Bus bundle between the interrupt sequencer, the pipeline hazard unit and the CSR block.
// master = sequencer side, slave = CSR/pipeline side.
interface irq_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned CODE_W = 5;

  logic              irq_sw;
  logic              irq_timer;
  logic              irq_ext;
  logic              mstatus_mie;
  logic [XLEN-1:0]   mie;
  logic [XLEN-1:0]   mtvec;
  logic [XLEN-1:0]   mepc;
  logic              mret;
  logic              pipe_ready;

  logic [XLEN-1:0]   mip;
  logic              stall;
  logic              int_action;
  logic              ret_action;
  logic              hw_int;
  logic [CODE_W-1:0] int_code;
  logic              flush;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;

  modport master (
    input  irq_sw, irq_timer, irq_ext, mstatus_mie, mie, mtvec, mepc, mret, pipe_ready,
    output mip, stall, int_action, ret_action, hw_int, int_code, flush, redirect, redirect_pc
  );

  modport slave (
    output irq_sw, irq_timer, irq_ext, mstatus_mie, mie, mtvec, mepc, mret, pipe_ready,
    input  mip, stall, int_action, ret_action, hw_int, int_code, flush, redirect, redirect_pc
  );
endinterface

// File: rtl/irq_sequencer.sv
// Machine-mode interrupt/return sequencer: syncs irq lines, picks the winning cause, drains, traps or returns.
// Define IRQ_VECTORED_EN to enable vectored trap targets when mtvec mode is 2'b01.
module irq_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned XLEN        = 32
) (
  input  logic             clk,
  input  logic             reset,
  irq_sequencer_if.master  bus
);

  localparam int unsigned CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_SW  = CODE_W'(3);
  localparam logic [CODE_W-1:0] CODE_TMR = CODE_W'(7);
  localparam logic [CODE_W-1:0] CODE_EXT = CODE_W'(11);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_TRAP  = 2'd2,
    S_RET   = 2'd3
  } state_e;

  // Per-line synchronizer chains, bit order {ext, timer, sw}
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] irq_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bus.irq_ext, bus.irq_timer, bus.irq_sw};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];

  logic [XLEN-1:0] mip_w;
  always_comb begin
    mip_w     = '0;
    mip_w[3]  = irq_s[0];
    mip_w[7]  = irq_s[1];
    mip_w[11] = irq_s[2];
  end

  logic pend_sw, pend_tmr, pend_ext, take;
  logic [CODE_W-1:0] prio_code;

  assign pend_sw  = irq_s[0] & bus.mie[3];
  assign pend_tmr = irq_s[1] & bus.mie[7];
  assign pend_ext = irq_s[2] & bus.mie[11];
  assign take     = bus.mstatus_mie & (pend_sw | pend_tmr | pend_ext);

  // Fixed priority ext > sw > timer
  always_comb begin
    prio_code = '0;
    if (pend_ext)      prio_code = CODE_EXT;
    else if (pend_sw)  prio_code = CODE_SW;
    else if (pend_tmr) prio_code = CODE_TMR;
  end

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;

  logic              stall_q, int_action_q, ret_action_q, hw_int_q, flush_q, redirect_q;
  logic [CODE_W-1:0] int_code_q;
  logic [XLEN-1:0]   redirect_pc_q;

  logic              stall_d, int_action_d, ret_action_d, hw_int_d, flush_d, redirect_d;
  logic [CODE_W-1:0] int_code_d;
  logic [XLEN-1:0]   redirect_pc_d;
  logic [XLEN-1:0]   trap_base, trap_pc;

  // State, latched cause and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      code_q        <= '0;
      stall_q       <= 1'b0;
      int_action_q  <= 1'b0;
      ret_action_q  <= 1'b0;
      hw_int_q      <= 1'b0;
      int_code_q    <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      stall_q       <= stall_d;
      int_action_q  <= int_action_d;
      ret_action_q  <= ret_action_d;
      hw_int_q      <= hw_int_d;
      int_code_q    <= int_code_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Next state; cause is re-evaluated every cycle while waiting so a higher source can preempt
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_DRAIN;
          code_d  = prio_code;
        end else if (bus.mret) begin
          state_d = S_RET;
        end
      end
      S_DRAIN: begin
        if (!take) begin
          state_d = S_IDLE;
        end else begin
          code_d = prio_code;
          if (bus.pipe_ready) state_d = S_TRAP;
        end
      end
      S_TRAP:  state_d = S_IDLE;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    trap_base = {bus.mtvec[XLEN-1:2], 2'b00};
`ifdef IRQ_VECTORED_EN
    if (bus.mtvec[1:0] == 2'b01) trap_pc = trap_base + XLEN'({code_d, 2'b00});
    else                         trap_pc = trap_base;
`else
    trap_pc = trap_base;
`endif
  end

  // Outputs decoded from the upcoming state so they line up with the state register
  always_comb begin
    stall_d       = 1'b0;
    int_action_d  = 1'b0;
    ret_action_d  = 1'b0;
    hw_int_d      = 1'b0;
    int_code_d    = '0;
    flush_d       = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    case (state_d)
      S_DRAIN: stall_d = 1'b1;
      S_TRAP: begin
        stall_d       = 1'b1;
        int_action_d  = 1'b1;
        hw_int_d      = 1'b1;
        int_code_d    = code_d;
        flush_d       = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = trap_pc;
      end
      S_RET: begin
        ret_action_d  = 1'b1;
        flush_d       = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = bus.mepc;
      end
      default: ;
    endcase
  end

  assign bus.mip         = mip_w;
  assign bus.stall       = stall_q;
  assign bus.int_action  = int_action_q;
  assign bus.ret_action  = ret_action_q;
  assign bus.hw_int      = hw_int_q;
  assign bus.int_code    = int_code_q;
  assign bus.flush       = flush_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;

  // CSR bits this block does not consume
  logic unused_bits;
  assign unused_bits = ^{bus.mie[XLEN-1:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0], bus.mtvec[1:0]};

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: directed stimulus pushes expected trap/return pulses, a monitor pops them.
module tb_irq_sequencer;

  localparam int unsigned XLEN = 32;

`ifdef IRQ_VECTORED_EN
  localparam logic [31:0] PC_EXT = 32'h0000_012C;
  localparam logic [31:0] PC_SW  = 32'h0000_010C;
  localparam logic [31:0] PC_TMR = 32'h0000_011C;
`else
  localparam logic [31:0] PC_EXT = 32'h0000_0100;
  localparam logic [31:0] PC_SW  = 32'h0000_0100;
  localparam logic [31:0] PC_TMR = 32'h0000_0100;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  irq_sequencer_if #(.XLEN(XLEN)) bus ();

  irq_sequencer #(.SYNC_STAGES(2), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        int_a;
    logic        ret_a;
    logic        hw;
    logic [4:0]  code;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  logic prev_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic ia, input logic ra, input logic hw,
                                  input logic [4:0] code, input logic [31:0] pc);
    exp_t e;
    e.int_a = ia;
    e.ret_a = ra;
    e.hw    = hw;
    e.code  = code;
    e.pc    = pc;
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every trap/return pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (bus.int_action | bus.ret_action | bus.flush | bus.redirect) begin
      chk("pulse_len", 32'(prev_pulse), 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: int_action=%0b ret_action=%0b pc=0x%0h with no entry queued at %0t",
                 bus.int_action, bus.ret_action, bus.redirect_pc, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("int_action",  32'(bus.int_action), 32'(mon_e.int_a));
        chk("ret_action",  32'(bus.ret_action), 32'(mon_e.ret_a));
        chk("hw_int",      32'(bus.hw_int),     32'(mon_e.hw));
        chk("int_code",    32'(bus.int_code),   32'(mon_e.code));
        chk("flush",       32'(bus.flush),      32'd1);
        chk("redirect",    32'(bus.redirect),   32'd1);
        chk("redirect_pc", bus.redirect_pc,     mon_e.pc);
      end
    end
    prev_pulse = bus.int_action | bus.ret_action | bus.flush | bus.redirect;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with everything asserted
    bus.irq_sw      = 1'b1;
    bus.irq_timer   = 1'b1;
    bus.irq_ext     = 1'b1;
    bus.mstatus_mie = 1'b1;
    bus.mie         = '1;
    bus.mtvec       = 32'h0000_0101;
    bus.mepc        = 32'h0000_2000;
    bus.mret        = 1'b1;
    bus.pipe_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_mip",   bus.mip, 32'd0);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      chk("rst_pulses", 32'({bus.int_action, bus.ret_action, bus.flush, bus.redirect, bus.hw_int}), 32'd0);
      chk("rst_code",  32'(bus.int_code), 32'd0);
      chk("rst_pc",    bus.redirect_pc, 32'd0);
    end
    bus.irq_sw = 1'b0; bus.irq_timer = 1'b0; bus.irq_ext = 1'b0;
    bus.mret = 1'b0; bus.mie = '0; bus.mstatus_mie = 1'b0;
    step(1);
    reset = 1'b0;
    step(2);

    // Timer trap with pipeline ready
    bus.mie = 32'h80; bus.mstatus_mie = 1'b1; bus.pipe_ready = 1'b1;
    sb.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd7, PC_TMR));
    bus.irq_timer = 1'b1;
    step(1); chk("tmr_mip_lag", bus.mip, 32'd0);
    step(1); chk("tmr_mip", bus.mip, 32'h80); chk("tmr_idle_stall", 32'(bus.stall), 32'd0);
    step(1); chk("tmr_drain_stall", 32'(bus.stall), 32'd1); chk("tmr_drain_noint", 32'(bus.int_action), 32'd0);
    step(1); chk("tmr_trap_stall", 32'(bus.stall), 32'd1);
    bus.mstatus_mie = 1'b0; bus.irq_timer = 1'b0;
    step(1); chk("tmr_post_stall", 32'(bus.stall), 32'd0);
    step(2); chk("tmr_mip_clear", bus.mip, 32'd0);

    // All three sources: external wins
    bus.mie = 32'h888; bus.mstatus_mie = 1'b1;
    sb.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd11, PC_EXT));
    bus.irq_sw = 1'b1; bus.irq_timer = 1'b1; bus.irq_ext = 1'b1;
    step(2); chk("all_mip", bus.mip, 32'h888);
    step(2);
    bus.mstatus_mie = 1'b0; bus.irq_sw = 1'b0; bus.irq_timer = 1'b0; bus.irq_ext = 1'b0;
    step(3); chk("all_mip_clear", bus.mip, 32'd0);

    // External dropped while draining: cause re-evaluates to software
    bus.pipe_ready = 1'b0; bus.mstatus_mie = 1'b1;
    bus.irq_sw = 1'b1; bus.irq_timer = 1'b1; bus.irq_ext = 1'b1;
    step(3); chk("pre_drain_stall", 32'(bus.stall), 32'd1);
    bus.irq_ext = 1'b0;
    step(4); chk("pre_mip", bus.mip, 32'h088); chk("pre_still_stall", 32'(bus.stall), 32'd1);
    sb.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd3, PC_SW));
    bus.pipe_ready = 1'b1;
    step(1);
    bus.mstatus_mie = 1'b0; bus.irq_sw = 1'b0; bus.irq_timer = 1'b0;
    step(3); chk("pre_mip_clear", bus.mip, 32'd0);

    // Drain aborted by clearing MIE
    bus.mie = 32'h008; bus.mstatus_mie = 1'b1; bus.pipe_ready = 1'b0;
    bus.irq_sw = 1'b1;
    step(3); chk("abort_stall", 32'(bus.stall), 32'd1);
    step(4); chk("abort_stall_hold", 32'(bus.stall), 32'd1);
    bus.mstatus_mie = 1'b0;
    step(1); chk("abort_release", 32'(bus.stall), 32'd0);
    bus.irq_sw = 1'b0; bus.pipe_ready = 1'b1;
    step(3); chk("abort_mip_clear", bus.mip, 32'd0);

    // mret with nothing pending
    bus.mie = '0; bus.mstatus_mie = 1'b1; bus.mepc = 32'h0000_2000;
    sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_2000));
    bus.mret = 1'b1;
    step(1);
    bus.mret = 1'b0;
    chk("ret_action_hi", 32'(bus.ret_action), 32'd1);
    chk("ret_no_stall",  32'(bus.stall), 32'd0);
    step(1);
    chk("ret_action_lo", 32'(bus.ret_action), 32'd0);
    chk("ret_flush_lo",  32'(bus.flush), 32'd0);

    // mret loses to an enabled pending interrupt
    bus.mie = 32'h80; bus.pipe_ready = 1'b1;
    bus.irq_timer = 1'b1;
    step(2);
    sb.push_back(mk_exp(1'b1, 1'b0, 1'b1, 5'd7, PC_TMR));
    bus.mret = 1'b1;
    step(1);
    bus.mret = 1'b0;
    chk("mret_lost_ret", 32'(bus.ret_action), 32'd0);
    chk("mret_lost_stall", 32'(bus.stall), 32'd1);
    step(1);
    bus.mstatus_mie = 1'b0; bus.irq_timer = 1'b0;
    step(3); chk("mret_mip_clear", bus.mip, 32'd0);

    // Asynchronous reset while draining
    bus.mie = 32'h008; bus.mstatus_mie = 1'b1; bus.pipe_ready = 1'b0;
    bus.irq_sw = 1'b1;
    step(3); chk("arst_pre_stall", 32'(bus.stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_mip",   bus.mip, 32'd0);
    bus.irq_sw = 1'b0; bus.mstatus_mie = 1'b0;
    step(1);
    reset = 1'b0; bus.pipe_ready = 1'b1;
    step(3);
    chk("arst_idle_stall", 32'(bus.stall), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
